// File: rtl/cpu16_pkg.sv
// Shared constants and FSM state type for the 16-bit register-file support blocks.
package cpu16_pkg;

    localparam int unsigned RF_DATA_W = 16;
    localparam int unsigned RF_ADDR_W = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_VERIFY,
        S_DONE
    } state_t;

endpackage

// File: rtl/rf_sum_acc.sv
// Modulo-2^DATA_W running-sum accumulator with synchronous clear and enable.
module rf_sum_acc #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] sum
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum <= '0;
        end else if (clear) begin
            sum <= '0;
        end else if (en) begin
            sum <= sum + din;
        end
    end

endmodule

// File: rtl/rf_boot_loader.sv
// Boot loader: streams words into RF registers FIRST_REG..LAST_REG, reads them back
// and compares write/read checksums, reporting PASS or FAIL.
module rf_boot_loader
    import cpu16_pkg::*;
#(
    parameter int unsigned DATA_W    = RF_DATA_W,
    parameter int unsigned ADDR_W    = RF_ADDR_W,
    parameter int unsigned FIRST_REG = 0,
    parameter int unsigned LAST_REG  = 7
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              START,
    input  logic              ABORT,
    input  logic [DATA_W-1:0] IN_DATA,
    input  logic              IN_VLD,
    output logic              IN_RDY,
    output logic [DATA_W-1:0] WD,
    output logic [ADDR_W-1:0] WR,
    output logic              WEn,
    output logic [ADDR_W-1:0] RR1,
    input  logic [DATA_W-1:0] RD1,
    output logic              BUSY,
    output logic              DONE,
    output logic              PASS,
    output logic              FAIL
);

    localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_REG);

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic              rdy_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;
    logic              fail_q;

    logic              in_load;
    logic              in_verify;
    logic              start_go;
    logic              wr_hs;
    logic              rd_en;
    logic              at_last;
    logic              sums_match;
    logic [DATA_W-1:0] wsum;
    logic [DATA_W-1:0] rsum;
    logic [DATA_W-1:0] rsum_final;

    always_comb begin
        in_load    = (state == S_LOAD);
        in_verify  = (state == S_VERIFY);
        start_go   = (state == S_IDLE) && START;
        wr_hs      = in_load && IN_VLD && !ABORT;
        rd_en      = in_verify && !ABORT;
        at_last    = (ptr == LAST_A);
        // The final RD1 has not reached rsum yet on the last verify cycle.
        rsum_final = rsum + RD1;
        sums_match = (wsum == rsum_final);
    end

    rf_sum_acc #(.DATA_W(DATA_W)) u_wsum (
        .clk  (CLK),
        .rst  (CLR),
        .clear(start_go),
        .en   (wr_hs),
        .din  (IN_DATA),
        .sum  (wsum)
    );

    rf_sum_acc #(.DATA_W(DATA_W)) u_rsum (
        .clk  (CLK),
        .rst  (CLR),
        .clear(start_go),
        .en   (rd_en),
        .din  (RD1),
        .sum  (rsum)
    );

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state  <= S_IDLE;
            ptr    <= FIRST_A;
            rdy_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
            fail_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        state  <= S_LOAD;
                        ptr    <= FIRST_A;
                        rdy_q  <= 1'b1;
                        busy_q <= 1'b1;
                        pass_q <= 1'b0;
                        fail_q <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (ABORT) begin
                        state  <= S_IDLE;
                        ptr    <= FIRST_A;
                        rdy_q  <= 1'b0;
                        busy_q <= 1'b0;
                        fail_q <= 1'b1;
                    end else if (IN_VLD) begin
                        if (at_last) begin
                            state <= S_VERIFY;
                            ptr   <= FIRST_A;
                            rdy_q <= 1'b0;
                        end else begin
                            ptr <= ptr + ADDR_W'(1);
                        end
                    end
                end
                S_VERIFY: begin
                    if (ABORT) begin
                        state  <= S_IDLE;
                        ptr    <= FIRST_A;
                        busy_q <= 1'b0;
                        fail_q <= 1'b1;
                    end else if (at_last) begin
                        // Verdict registered here so it appears together with DONE.
                        state  <= S_DONE;
                        ptr    <= FIRST_A;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        pass_q <= sums_match;
                        fail_q <= !sums_match;
                    end else begin
                        ptr <= ptr + ADDR_W'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state  <= S_IDLE;
                    ptr    <= FIRST_A;
                    rdy_q  <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        IN_RDY = rdy_q;
        WEn    = wr_hs;
        WD     = in_load ? IN_DATA : '0;
        WR     = ptr;
        RR1    = ptr;
        BUSY   = busy_q;
        DONE   = done_q;
        PASS   = pass_q;
        FAIL   = fail_q;
    end

endmodule

// File: tb/tb_rf_boot_loader.sv
// Directed + randomized bench for rf_boot_loader with an attached register-file model.
module tb_rf_boot_loader;

    localparam int DW = 16;
    localparam int AW = 3;
    localparam int N  = 8;

    logic          CLK = 1'b0;
    logic          CLR;
    logic          START;
    logic          ABORT;
    logic [DW-1:0] IN_DATA;
    logic          IN_VLD;
    logic          IN_RDY;
    logic [DW-1:0] WD;
    logic [AW-1:0] WR;
    logic          WEn;
    logic [AW-1:0] RR1;
    logic [DW-1:0] RD1;
    logic          BUSY;
    logic          DONE;
    logic          PASS;
    logic          FAIL;

    logic [DW-1:0] rf [0:N-1];
    logic [DW-1:0] w  [0:N-1];
    bit            corrupt_en;
    int            corrupt_idx;
    logic [DW-1:0] corrupt_mask;

    int checks = 0;
    int errors = 0;

    rf_boot_loader #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .FIRST_REG(0),
        .LAST_REG (N - 1)
    ) dut (
        .CLK    (CLK),
        .CLR    (CLR),
        .START  (START),
        .ABORT  (ABORT),
        .IN_DATA(IN_DATA),
        .IN_VLD (IN_VLD),
        .IN_RDY (IN_RDY),
        .WD     (WD),
        .WR     (WR),
        .WEn    (WEn),
        .RR1    (RR1),
        .RD1    (RD1),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .PASS   (PASS),
        .FAIL   (FAIL)
    );

    always #5 CLK = ~CLK;

    // Register file model; optional single-register read corruption.
    always @(posedge CLK) begin
        if (WEn) rf[WR] <= WD;
    end
    assign RD1 = rf[RR1] ^ ((corrupt_en && (int'(RR1) == corrupt_idx)) ? corrupt_mask : '0);

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference verdict: checksum of written words vs checksum of what reads back.
    function automatic bit model_pass();
        int ws = 0;
        int rs = 0;
        for (int i = 0; i < N; i++) begin
            ws = (ws + int'(w[i])) % 65536;
            if (corrupt_en && i == corrupt_idx) rs = (rs + int'(w[i] ^ corrupt_mask)) % 65536;
            else                               rs = (rs + int'(w[i])) % 65536;
        end
        return ws == rs;
    endfunction

    task automatic do_start();
        @(negedge CLK);
        START  = 1'b1;
        ABORT  = 1'b0;
        IN_VLD = 1'b0;
        #1;
        check("idle_busy", BUSY, 0);
    endtask

    // vmode: 0 back-to-back, 1 alternating valid, 2 random valid.
    task automatic load_phase(input int vmode, input int stop_after, input int start_glitch,
                              input int abort_at, output int accepted);
        int k   = 0;
        int cyc = 0;
        while (k < N && cyc < 200) begin
            @(negedge CLK);
            START = (cyc == start_glitch);
            ABORT = (cyc == abort_at);
            case (vmode)
                0:       IN_VLD = 1'b1;
                1:       IN_VLD = ((cyc % 2) == 0);
                default: IN_VLD = 1'($urandom_range(0, 1));
            endcase
            IN_DATA = IN_VLD ? w[k] : DW'($urandom);
            #1;
            if (cyc == 0) begin
                check("start_clr_pass", PASS, 0);
                check("start_clr_fail", FAIL, 0);
            end
            check("load_rdy", IN_RDY, 1);
            check("load_busy", BUSY, 1);
            check("load_wr", WR, k);
            check("load_wd", WD, IN_DATA);
            check("load_wen", WEn, IN_VLD && !ABORT);
            check("load_done", DONE, 0);
            if (ABORT) begin
                accepted = k;
                return;
            end
            if (IN_VLD) k++;
            cyc++;
            if (stop_after >= 0 && k == stop_after) break;
        end
        if (stop_after < 0) check("load_count", k, N);
        accepted = k;
    endtask

    task automatic verify_phase(input int abort_at);
        for (int i = 0; i < N; i++) begin
            @(negedge CLK);
            IN_VLD = 1'b0;
            START  = 1'b0;
            ABORT  = (i == abort_at);
            #1;
            check("ver_rr1", RR1, i);
            check("ver_wen", WEn, 0);
            check("ver_rdy", IN_RDY, 0);
            check("ver_busy", BUSY, 1);
            check("ver_done", DONE, 0);
            if (ABORT) return;
        end
    endtask

    task automatic done_phase(input bit exp_pass);
        @(negedge CLK);
        ABORT = 1'b0;
        #1;
        check("done_pulse", DONE, 1);
        check("done_pass", PASS, exp_pass);
        check("done_fail", FAIL, !exp_pass);
        check("done_busy", BUSY, 0);
        @(negedge CLK);
        #1;
        check("done_low", DONE, 0);
        check("pass_sticky", PASS, exp_pass);
        check("fail_sticky", FAIL, !exp_pass);
        check("idle_rdy", IN_RDY, 0);
    endtask

    initial begin
        int       acc;
        bit       exp_pass;
        logic [DW-1:0] prev4;

        for (int i = 0; i < N; i++) rf[i] = '0;
        corrupt_en   = 1'b0;
        corrupt_idx  = 0;
        corrupt_mask = '0;
        START   = 1'b0;
        ABORT   = 1'b0;
        IN_VLD  = 1'b0;
        IN_DATA = '0;

        // 1: reset state
        CLR = 1'b1;
        #120;
        check("rst_wen", WEn, 0);
        check("rst_rdy", IN_RDY, 0);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_pass", PASS, 0);
        check("rst_fail", FAIL, 0);
        check("rst_wr", WR, 0);
        check("rst_rr1", RR1, 0);
        check("rst_wd", WD, 0);
        @(negedge CLK);
        CLR = 1'b0;

        // ABORT in IDLE is ignored
        @(negedge CLK);
        ABORT = 1'b1;
        @(negedge CLK);
        ABORT = 1'b0;
        #1;
        check("idle_abort_fail", FAIL, 0);
        check("idle_abort_busy", BUSY, 0);

        // 2: back-to-back fixed words
        w[0] = 16'h0008; w[1] = 16'h0020; w[2] = 16'h0001; w[3] = 16'h0002;
        w[4] = 16'h0003; w[5] = 16'h0004; w[6] = 16'h0005; w[7] = 16'h4000;
        do_start();
        load_phase(0, -1, -1, -1, acc);
        verify_phase(-1);
        done_phase(model_pass());
        check("reg7", rf[7], 16'h4000);

        // 3: alternating valid
        for (int i = 0; i < N; i++) w[i] = DW'($urandom);
        do_start();
        load_phase(1, -1, -1, -1, acc);
        verify_phase(-1);
        done_phase(model_pass());
        check("reg5_6th_word", rf[5], w[5]);

        // 4: corrupted readback of reg5
        for (int i = 0; i < N; i++) w[i] = DW'($urandom);
        w[5]         = 16'h0500;
        corrupt_en   = 1'b1;
        corrupt_idx  = 5;
        corrupt_mask = 16'h0001;
        exp_pass     = model_pass();
        check("model_corrupt", exp_pass, 0);
        do_start();
        load_phase(0, -1, -1, -1, acc);
        verify_phase(-1);
        done_phase(exp_pass);
        corrupt_en = 1'b0;

        // 5: CLR after three writes
        for (int i = 0; i < N; i++) w[i] = DW'($urandom);
        do_start();
        load_phase(0, 3, -1, -1, acc);
        @(negedge CLK);
        IN_VLD  = 1'b1;
        IN_DATA = DW'($urandom);
        CLR     = 1'b1;
        #1;
        check("clr_busy", BUSY, 0);
        check("clr_wen", WEn, 0);
        check("clr_rdy", IN_RDY, 0);
        check("clr_wr", WR, 0);
        check("clr_done", DONE, 0);
        for (int i = 0; i < 3; i++) check("clr_prior_write", rf[i], w[i]);
        @(negedge CLK);
        CLR    = 1'b0;
        IN_VLD = 1'b0;
        do_start();
        load_phase(0, -1, -1, -1, acc);
        verify_phase(-1);
        done_phase(model_pass());

        // 6: START glitch during LOAD, then ABORT in VERIFY
        for (int i = 0; i < N; i++) w[i] = DW'($urandom);
        do_start();
        load_phase(2, -1, 3, -1, acc);
        verify_phase(3);
        @(negedge CLK);
        ABORT = 1'b0;
        #1;
        check("abort_busy", BUSY, 0);
        check("abort_fail", FAIL, 1);
        check("abort_pass", PASS, 0);
        for (int i = 0; i < 4; i++) begin
            check("abort_no_done", DONE, 0);
            @(negedge CLK);
            #1;
        end

        // ABORT in LOAD with simultaneous handshake: no write
        prev4 = w[4];
        for (int i = 0; i < N; i++) w[i] = DW'($urandom);
        w[4] = ~prev4;
        do_start();
        load_phase(0, -1, -1, 4, acc);
        check("abort_load_acc", acc, 4);
        @(negedge CLK);
        ABORT  = 1'b0;
        IN_VLD = 1'b0;
        #1;
        check("abort_load_busy", BUSY, 0);
        check("abort_load_fail", FAIL, 1);
        check("abort_load_done", DONE, 0);
        check("abort_load_reg4", rf[4], prev4);

        // randomized runs
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++) w[i] = DW'($urandom);
            corrupt_en   = 1'($urandom_range(0, 1));
            corrupt_idx  = int'($urandom_range(0, N - 1));
            corrupt_mask = DW'($urandom_range(1, 65535));
            do_start();
            load_phase(2, -1, -1, -1, acc);
            verify_phase(-1);
            done_phase(model_pass());
            for (int i = 0; i < N; i++) check("rand_reg", rf[i], w[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
